// File: rtl/i2s_tx_sched_if.sv
// i2s_tx_sched_if: requester-side valid/ready bus shared by NUM_SRC sample sources
//   src_mask  : per-source arbitration eligibility
//   src_valid : per-source sample pair available
//   src_left  : packed left samples, source k at [k*AUDIO_DW +: AUDIO_DW]
//   src_right : packed right samples, same packing
//   src_ready : one-hot grant from the scheduler
//   master = sources side, slave = scheduler side
interface i2s_tx_sched_if #(
    parameter int NUM_SRC  = 4,
    parameter int AUDIO_DW = 24
);
    logic [NUM_SRC-1:0]          src_mask;
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC-1:0]          src_ready;
    logic [NUM_SRC*AUDIO_DW-1:0] src_left;
    logic [NUM_SRC*AUDIO_DW-1:0] src_right;
    modport master (output src_mask, src_valid, src_left, src_right, input src_ready);
    modport slave (input src_mask, src_valid, src_left, src_right, output src_ready);
endinterface

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: round-robin stereo sample scheduler feeding an I2S transmitter
//   sclk         : bit clock, all logic on rising edge
//   rst          : synchronous reset, active-low
//   enable       : run request, start/stop aligned to frame boundaries
//   bus          : requester valid/ready bus (slave side)
//   left_chan    : held left sample      right_chan : held right sample
//   frame_start  : high while frame counter is 0
//   grant_id     : index of last granted source
//   underrun     : one-cycle pulse when nothing eligible at the load point
//   underrun_cnt : saturating underrun count
//   busy         : scheduler not OFF
//   Macro I2S_SCHED_HOLD_EN: on underrun repeat the last sample instead of muting
module i2s_tx_sched #(
    parameter int AUDIO_DW  = 24,
    parameter int PRESCALER = 32,
    parameter int NUM_SRC   = 4,
    parameter int LOAD_CNT  = 2*PRESCALER-4
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       enable,
    i2s_tx_sched_if.slave              bus,
    output logic [AUDIO_DW-1:0]        left_chan,
    output logic [AUDIO_DW-1:0]        right_chan,
    output logic                       frame_start,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       underrun,
    output logic [15:0]                underrun_cnt,
    output logic                       busy
);
    localparam int FW = $clog2(2*PRESCALER);
    localparam int IW = $clog2(NUM_SRC);
    localparam logic [FW-1:0] LAST = FW'(2*PRESCALER-1);
    localparam logic [FW-1:0] LOAD = FW'(LOAD_CNT);

    typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [FW-1:0]     frame_cnt;
    logic [IW-1:0]     ptr, win, idx;
    logic [NUM_SRC-1:0] cand;
    logic              found, frame_end, load_cyc, grant;

    assign cand      = bus.src_valid & bus.src_mask;
    assign frame_end = frame_cnt == LAST;
    assign load_cyc  = frame_cnt == LOAD;
    assign grant     = state == RUN && load_cyc && found;
    assign bus.src_ready = grant ? NUM_SRC'(1) << win : '0;

    // first candidate after the pointer, wrapping, so the last winner has lowest priority
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_SRC);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // OFF only leaves at a frame end; DRAIN finishes the current frame unless re-enabled
    always_comb begin
        state_nxt = state == OFF ? (enable && frame_end ? RUN : OFF)
                  : state == RUN ? (enable ? RUN : DRAIN)
                  : (enable ? RUN : frame_end ? OFF : DRAIN);
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            frame_cnt    <= '0;
            state        <= OFF;
            busy         <= 1'b0;
            frame_start  <= 1'b0;
            left_chan    <= '0;
            right_chan   <= '0;
            grant_id     <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            ptr          <= IW'(NUM_SRC-1);
        end else begin
            frame_cnt   <= frame_end ? '0 : frame_cnt + 1'b1;
            frame_start <= frame_end;
            state       <= state_nxt;
            busy        <= state_nxt != OFF;
            underrun    <= 1'b0;
            if (load_cyc) begin
                if (state != RUN) begin
                    left_chan  <= '0;
                    right_chan <= '0;
                end else if (found) begin
                    left_chan  <= bus.src_left[int'(win)*AUDIO_DW +: AUDIO_DW];
                    right_chan <= bus.src_right[int'(win)*AUDIO_DW +: AUDIO_DW];
                    grant_id   <= win;
                    ptr        <= win;
                end else begin
                    underrun <= 1'b1;
                    if (underrun_cnt != 16'hFFFF)
                        underrun_cnt <= underrun_cnt + 1'b1;
`ifdef I2S_SCHED_HOLD_EN
                    left_chan  <= left_chan;
                    right_chan <= right_chan;
`else
                    left_chan  <= '0;
                    right_chan <= '0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched: directed self-checking bench for i2s_tx_sched (PRESCALER=32, NUM_SRC=4, LOAD_CNT=60)
module tb_i2s_tx_sched;
    logic        sclk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] left_chan, right_chan;
    logic        frame_start, underrun, busy;
    logic [1:0]  grant_id;
    logic [15:0] underrun_cnt;
    int          checks = 0;
    int          errors = 0;
    int          tfc = 0;
    logic [23:0] mute_l, mute_r;

    i2s_tx_sched_if #(.NUM_SRC(4), .AUDIO_DW(24)) bus ();

    i2s_tx_sched #(.AUDIO_DW(24), .PRESCALER(32), .NUM_SRC(4), .LOAD_CNT(60)) dut (
        .sclk(sclk), .rst(rst), .enable(enable), .bus(bus),
        .left_chan(left_chan), .right_chan(right_chan), .frame_start(frame_start),
        .grant_id(grant_id), .underrun(underrun), .underrun_cnt(underrun_cnt), .busy(busy)
    );

    always #5 sclk = ~sclk;

    // reference frame position: 0..63, restarting from 0 on reset
    always @(posedge sclk) tfc <= !rst ? 0 : (tfc == 63 ? 0 : tfc + 1);

    function automatic logic [23:0] lv(input int k);
        return 24'hA00000 | 24'(k);
    endfunction

    function automatic logic [23:0] rv(input int k);
        return 24'h500000 | 24'(k);
    endfunction

    task automatic set_src(input logic [3:0] valid, input logic [3:0] mask);
        bus.src_valid = valid;
        bus.src_mask  = mask;
        for (int k = 0; k < 4; k++) begin
            bus.src_left[k*24 +: 24]  = lv(k);
            bus.src_right[k*24 +: 24] = rv(k);
        end
    endtask

    // advance to the next negedge where the frame position equals n
    task automatic goto(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            if (tfc == n) return;
        end
        checks++;
        errors++;
        $display("FAIL goto timeout waiting for frame_cnt %0d", n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        set_src(4'hF, 4'hF);
        repeat (3) @(negedge sclk);
        checks++;
        if ({left_chan, right_chan, bus.src_ready, grant_id, underrun, underrun_cnt, busy, frame_start} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got l=%h r=%h rdy=%b gid=%0d ur=%b cnt=%0d busy=%b fs=%b exp all 0",
                     left_chan, right_chan, bus.src_ready, grant_id, underrun, underrun_cnt, busy, frame_start);
        end
        rst = 1'b1;
        goto(0);
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_hi got %b exp 1", frame_start); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL off_busy got %b exp 0", busy); end
        goto(1);
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_lo got %b exp 0", frame_start); end
        goto(60);
        checks++;
        if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL off_no_ready got %b exp 0000", bus.src_ready); end
    endtask

    task automatic test_round_robin();
        enable = 1'b1;
        goto(0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b exp 1", busy); end
        for (int f = 0; f < 5; f++) begin
            goto(60);
            checks++;
            if (bus.src_ready !== (4'b0001 << (f % 4))) begin
                errors++; $display("FAIL rr_ready f%0d got %b exp %b", f, bus.src_ready, 4'b0001 << (f % 4));
            end
            goto(61);
            checks++;
            if (left_chan !== lv(f % 4) || right_chan !== rv(f % 4) || grant_id !== 2'(f % 4)) begin
                errors++; $display("FAIL rr_data f%0d got l=%h r=%h gid=%0d exp l=%h r=%h gid=%0d",
                                   f, left_chan, right_chan, grant_id, lv(f % 4), rv(f % 4), f % 4);
            end
        end
    endtask

    task automatic test_single_source();
        int exp_seq[5] = '{2, 2, 2, 1, 2};
        set_src(4'b0100, 4'hF);
        for (int f = 0; f < 5; f++) begin
            if (f == 3) bus.src_valid = 4'b0110;
            goto(60);
            checks++;
            if (bus.src_ready !== (4'b0001 << exp_seq[f])) begin
                errors++; $display("FAIL single_ready f%0d got %b exp %b", f, bus.src_ready, 4'b0001 << exp_seq[f]);
            end
            goto(61);
            checks++;
            if (grant_id !== 2'(exp_seq[f]) || left_chan !== lv(exp_seq[f])) begin
                errors++; $display("FAIL single_data f%0d got gid=%0d l=%h exp gid=%0d l=%h",
                                   f, grant_id, left_chan, exp_seq[f], lv(exp_seq[f]));
            end
        end
    endtask

    task automatic test_underrun();
`ifdef I2S_SCHED_HOLD_EN
        mute_l = 24'h123456;
        mute_r = 24'hABCDEF;
`else
        mute_l = 24'h000000;
        mute_r = 24'h000000;
`endif
        set_src(4'b0001, 4'hF);
        bus.src_left[23:0]  = 24'h123456;
        bus.src_right[23:0] = 24'hABCDEF;
        goto(61);
        checks++;
        if (left_chan !== 24'h123456 || right_chan !== 24'hABCDEF || underrun_cnt !== 16'd0) begin
            errors++; $display("FAIL ur_seed got l=%h r=%h cnt=%0d exp l=123456 r=abcdef cnt=0",
                               left_chan, right_chan, underrun_cnt);
        end
        bus.src_valid = 4'b0000;
        for (int f = 0; f < 5; f++) begin
            goto(60);
            checks++;
            if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL ur_ready f%0d got %b exp 0000", f, bus.src_ready); end
            goto(61);
            checks++;
            if (underrun !== 1'b1 || left_chan !== mute_l || right_chan !== mute_r) begin
                errors++; $display("FAIL ur_pulse f%0d got ur=%b l=%h r=%h exp ur=1 l=%h r=%h",
                                   f, underrun, left_chan, right_chan, mute_l, mute_r);
            end
            goto(62);
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear f%0d got %b exp 0", f, underrun); end
        end
        checks++;
        if (underrun_cnt !== 16'd5) begin errors++; $display("FAIL ur_count got %0d exp 5", underrun_cnt); end
    endtask

    task automatic test_mask();
        set_src(4'hF, 4'b1010);
        for (int f = 0; f < 4; f++) begin
            goto(60);
            checks++;
            if (bus.src_ready !== (f % 2 == 1 ? 4'b1000 : 4'b0010)) begin
                errors++; $display("FAIL mask_ready f%0d got %b exp %b", f, bus.src_ready, f % 2 == 1 ? 4'b1000 : 4'b0010);
            end
            goto(61);
            checks++;
            if (grant_id !== (f % 2 == 1 ? 2'd3 : 2'd1)) begin
                errors++; $display("FAIL mask_gid f%0d got %0d exp %0d", f, grant_id, f % 2 == 1 ? 3 : 1);
            end
        end
    endtask

    task automatic test_drain();
        set_src(4'hF, 4'hF);
        goto(60);
        checks++;
        if (bus.src_ready !== 4'b0001) begin errors++; $display("FAIL drain_ready got %b exp 0001", bus.src_ready); end
        enable = 1'b0;
        goto(61);
        checks++;
        if (left_chan !== lv(0) || busy !== 1'b1) begin
            errors++; $display("FAIL drain_xfer got l=%h busy=%b exp l=%h busy=1", left_chan, busy, lv(0));
        end
        goto(63);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy63 got %b exp 1", busy); end
        goto(0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_off got %b exp 0", busy); end
        goto(60);
        checks++;
        if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL drain_noready got %b exp 0000", bus.src_ready); end
        goto(61);
        checks++;
        if (left_chan !== 24'h0 || right_chan !== 24'h0) begin
            errors++; $display("FAIL drain_zero got l=%h r=%h exp 0", left_chan, right_chan);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        goto(0);
        goto(60);
        checks++;
        if (bus.src_ready !== 4'b0010) begin errors++; $display("FAIL rm_ready1 got %b exp 0010", bus.src_ready); end
        goto(61);
        checks++;
        if (left_chan !== lv(1) || grant_id !== 2'd1) begin
            errors++; $display("FAIL rm_xfer got l=%h gid=%0d exp l=%h gid=1", left_chan, grant_id, lv(1));
        end
        goto(60);
        checks++;
        if (bus.src_ready !== 4'b0100) begin errors++; $display("FAIL rm_ready2 got %b exp 0100", bus.src_ready); end
        rst = 1'b0;
        @(negedge sclk);
        checks++;
        if (left_chan !== 24'h0 || right_chan !== 24'h0 || grant_id !== 2'd0 || busy !== 1'b0 || underrun_cnt !== 16'd0) begin
            errors++; $display("FAIL rm_abort got l=%h r=%h gid=%0d busy=%b cnt=%0d exp all 0",
                               left_chan, right_chan, grant_id, busy, underrun_cnt);
        end
        rst = 1'b1;
        goto(0);
        goto(60);
        checks++;
        if (bus.src_ready !== 4'b0001) begin errors++; $display("FAIL rm_restart got %b exp 0001", bus.src_ready); end
        goto(61);
        checks++;
        if (grant_id !== 2'd0 || left_chan !== lv(0)) begin
            errors++; $display("FAIL rm_restart_data got gid=%0d l=%h exp gid=0 l=%h", grant_id, left_chan, lv(0));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_source();
        test_underrun();
        test_mask();
        test_drain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
